bus_arbiter_2m: RTL and testbench
=================================

Name: bus_arbiter_2m

Overview:
- Two-master, one-slave arbiter on the native valid/ready memory bus (addr, wdata, wstrb, rdata). It sits directly upstream of the on-chip memory and peripheral slaves.
- Master 0 is the CPU; master 1 is the loader/debug port. Round-robin grant.
- Registered slave-side outputs. After every transaction, valid is forced low for one cycle so single-shot slaves re-arm.
- A per-transaction watchdog completes unanswered accesses (unmapped address) with a fixed read value and an error pulse.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in GRANT without s_ready_i before the transaction is force-completed (min 2).
- TIMEOUT_RDATA, 32'hDEAD_BEEF, rdata returned to the master on timeout.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- m0_valid_i  input  1  master 0 request
- m0_ready_o  output  1  master 0 completion pulse
- m0_addr_i  input  32  master 0 byte address
- m0_wdata_i  input  32  master 0 write data
- m0_wstrb_i  input  4  master 0 byte strobes; 0 = read
- m0_rdata_o  output  32  master 0 read data, valid with m0_ready_o
- m1_valid_i, m1_ready_o, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o: same as m0, for master 1
- s_valid_o  output  1  slave request
- s_ready_i  input  1  slave completion
- s_addr_o  output  32  slave address
- s_wdata_o  output  32  slave write data
- s_wstrb_o  output  4  slave strobes
- s_rdata_i  input  32  slave read data
- timeout_o  output  1  one-cycle pulse on watchdog completion
- err_addr_o  output  32  address of the most recent timed-out access, held until next timeout

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. last_grant = 1, so m0 wins the first tie. Watchdog counter 0. An in-flight transaction is abandoned with no ready pulse.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Sample m0_valid_i/m1_valid_i.
  - One requester: grant it.
  - Both: grant the master not equal to last_grant.
  - On grant, register that master's addr/wdata/wstrb onto s_*_o, set s_valid_o = 1, record grant, go to GRANT. Counter = 0.
  - No request: stay in IDLE, s_valid_o = 0.
- GRANT:
  - s_valid_o held at 1. s_addr_o/s_wdata_o/s_wstrb_o are stable and do not follow master inputs.
  - On s_ready_i = 1: capture s_rdata_i into the granted master's rdata_o and pulse its ready_o for exactly one cycle (next cycle). Drop s_valid_o, set last_grant = granted, go to RELEASE.
  - s_ready_i = 0 and counter == TIMEOUT_CYCLES-1: pulse granted ready_o with rdata_o = TIMEOUT_RDATA, and pulse timeout_o the same cycle. Load err_addr_o = s_addr_o, drop s_valid_o, set last_grant, go to RELEASE.
  - Otherwise increment the counter.
  - s_ready_i and timeout in the same cycle: s_ready_i wins, no timeout_o.
- RELEASE: exactly one cycle, s_valid_o = 0, no new grant. Then go to IDLE.
- Latency (slave answers k cycles after s_valid_o rises, k ≥ 1):
  - master valid sampled at edge N
  - s_valid_o high after N
  - s_ready_i at N+k
  - master ready_o high N+k+1
  - next grant earliest at N+k+3
- Non-granted master: ready_o = 0, rdata_o = 0 at all times.
- rdata_o is zero except in its ready cycle. For writes, rdata_o carries whatever s_rdata_i returned.
- s_ready_i while IDLE or RELEASE: ignored.
- A master dropping valid mid-transaction is a protocol violation. The arbiter still completes the slave access and issues the ready pulse.

Test Plan:
- Single read: m0 reads 0x0100_0010, slave answers k=1 with 0x1234_5678 -> m0_ready_o high at N+2 with m0_rdata_o = 0x1234_5678; s_valid_o high N+1..N+1 then low in RELEASE; m1 outputs stay 0.
- Contention: m0 and m1 request continuously, slave k=1 -> grants alternate m0, m1, m0, m1 after reset; s_valid_o has a ≥1-cycle low gap between grants; each master gets 4 completions in 8 transactions.
- Write passthrough: m1 writes 0xA5A5_A5A5, wstrb 4'b0011, addr 0x0100_0004; m1 inputs changed during GRANT -> s_wdata_o/s_wstrb_o/s_addr_o stay at the original values until ready.
- Timeout: TIMEOUT_CYCLES=4, m0 reads 0x2000_0000, s_ready_i never asserted -> m0_ready_o and timeout_o pulse together 4 cycles after s_valid_o rises; m0_rdata_o = 0xDEAD_BEEF; err_addr_o = 0x2000_0000 and holds.
- Ready vs timeout collision: TIMEOUT_CYCLES=4, s_ready_i in the 4th GRANT cycle with 0x0000_0042 -> normal completion with rdata 0x42, timeout_o stays 0.
- Reset mid-transaction: resetn low during GRANT -> all outputs 0 immediately (async); after release, simultaneous m0/m1 requests -> m0 granted first.

Source files
------------

// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_2m
//  Purpose  : Two-master / one-slave round-robin arbiter for the native
//             valid/ready memory bus. Slave-side outputs are registered. After
//             each transaction the slave valid is held low for one cycle so
//             single-shot slaves re-arm. A per-transaction watchdog completes
//             unanswered accesses with a fixed read value and an error pulse.
//  Ports    : clk, resetn            - clock / async active-low reset
//             m0_* / m1_*            - master request (valid, addr, wdata,
//                                      wstrb) and completion (ready, rdata)
//             s_*                    - slave request / completion
//             timeout_o              - one-cycle pulse on watchdog completion
//             err_addr_o             - address of last timed-out access
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid_i,
    output logic        m0_ready_o,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_valid_i,
    output logic        m1_ready_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic [31:0] m1_rdata_o,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic [31:0] s_rdata_i,
    output logic        timeout_o,
    output logic [31:0] err_addr_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;       // master currently owning the slave
    logic             last_q, last_d;     // master served most recently
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_valid_q, s_valid_d;
    logic [31:0]      s_addr_q, s_addr_d;
    logic [31:0]      s_wdata_q, s_wdata_d;
    logic [3:0]       s_wstrb_q, s_wstrb_d;
    logic             m0_ready_q, m0_ready_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic             m1_ready_q, m1_ready_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic             pick;               // winner of the IDLE-state arbitration
    logic             cpl;                // transaction completes this cycle
    logic [31:0]      cpl_rdata;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_valid_d  = s_valid_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m0_ready_d = 1'b0;
        m0_rdata_d = 32'h0;
        m1_ready_d = 1'b0;
        m1_rdata_d = 32'h0;
        timeout_d  = 1'b0;
        err_addr_d = err_addr_q;
        pick       = 1'b0;
        cpl        = 1'b0;
        cpl_rdata  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                s_valid_d = 1'b0;
                if (m0_valid_i || m1_valid_i) begin
                    // On a tie the master not served last wins.
                    pick      = (m0_valid_i && m1_valid_i) ? ~last_q : m1_valid_i;
                    gnt_d     = pick;
                    s_addr_d  = pick ? m1_addr_i  : m0_addr_i;
                    s_wdata_d = pick ? m1_wdata_i : m0_wdata_i;
                    s_wstrb_d = pick ? m1_wstrb_i : m0_wstrb_i;
                    s_valid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // A slave answer in the last watchdog cycle still counts as
                // a normal completion.
                if (s_ready_i) begin
                    cpl       = 1'b1;
                    cpl_rdata = s_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    cpl        = 1'b1;
                    cpl_rdata  = TIMEOUT_RDATA;
                    timeout_d  = 1'b1;
                    err_addr_d = s_addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (cpl) begin
                    s_valid_d = 1'b0;
                    last_d    = gnt_q;
                    state_d   = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Mandatory one-cycle valid-low gap between transactions.
                s_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                s_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (cpl) begin
            if (gnt_q) begin
                m1_ready_d = 1'b1;
                m1_rdata_d = cpl_rdata;
            end else begin
                m0_ready_d = 1'b1;
                m0_rdata_d = cpl_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            s_valid_q  <= 1'b0;
            s_addr_q   <= 32'h0;
            s_wdata_q  <= 32'h0;
            s_wstrb_q  <= 4'h0;
            m0_ready_q <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_ready_q <= 1'b0;
            m1_rdata_q <= 32'h0;
            timeout_q  <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            s_valid_q  <= s_valid_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m0_ready_q <= m0_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ready_q <= m1_ready_d;
            m1_rdata_q <= m1_rdata_d;
            timeout_q  <= timeout_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign s_valid_o  = s_valid_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;
    assign s_wstrb_o  = s_wstrb_q;
    assign m0_ready_o = m0_ready_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_ready_o = m1_ready_q;
    assign m1_rdata_o = m1_rdata_q;
    assign timeout_o  = timeout_q;
    assign err_addr_o = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bus_arbiter_2m
//  Purpose  : Self-checking bench for bus_arbiter_2m. A transaction-schedule
//             model predicts, for every cycle, slave valid/address window,
//             completion cycle, completion data, timeout and error address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_2m;

    localparam int          T       = 4;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid_i, m0_ready_o, m1_valid_i, m1_ready_o;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o, m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0]  m0_wstrb_i, m1_wstrb_i, s_wstrb_o;
    logic        s_valid_o, s_ready_i, timeout_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i, err_addr_o;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(TO_DATA)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid_i(m0_valid_i), .m0_ready_o(m0_ready_o), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i), .m1_ready_o(m1_ready_o), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o),
        .s_valid_o(s_valid_o), .s_ready_i(s_ready_i), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i),
        .timeout_o(timeout_o), .err_addr_o(err_addr_o)
    );

    int total = 0, bad = 0, cyc = 0;

    // stimulus knobs
    bit          rand_mode = 0, sticky = 0, scramble = 0, lit_w = 0;
    int          dir_lat = 1;
    logic [31:0] dir_rdata = 32'h0;
    bit          mreq [2];
    logic [31:0] maddr [2], mwdata [2];
    logic [3:0]  mwstrb [2];
    bit          srdy;
    logic [31:0] srdata;

    // transaction schedule model (absolute cycle numbers)
    int          t_vstart, t_done, t_ready, t_free, g_cyc;
    bit          tx_m, tx_to, last_winner;
    logic [31:0] tx_addr, tx_wdata, tx_rdata, exp_err;
    logic [3:0]  tx_wstrb;

    // observed completions
    bit          obs_m [$];
    int          obs_c [$];
    logic [31:0] obs_d [$];
    bit          obs_t [$];
    int          sv_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%08h want=%08h", nm, cyc, act, exp);
        end
    endtask

    task automatic apply_ports();
        m0_valid_i = mreq[0]; m0_addr_i = maddr[0]; m0_wdata_i = mwdata[0]; m0_wstrb_i = mwstrb[0];
        m1_valid_i = mreq[1]; m1_addr_i = maddr[1]; m1_wdata_i = mwdata[1]; m1_wstrb_i = mwstrb[1];
        s_ready_i  = srdy;    s_rdata_i = srdata;
    endtask

    task automatic model_reset();
        t_vstart = -100; t_done = -100; t_ready = -100; t_free = 0; g_cyc = -100;
        tx_m = 0; tx_to = 0; last_winner = 1; exp_err = 32'h0;
        tx_addr = 0; tx_wdata = 0; tx_wstrb = 0; tx_rdata = 0;
        mreq[0] = 0; mreq[1] = 0; srdy = 0; srdata = 0;
    endtask

    task automatic obs_clear();
        obs_m.delete(); obs_c.delete(); obs_d.delete(); obs_t.delete(); sv_cnt = 0;
    endtask

    task automatic check_outputs();
        bit sv, r0, r1;
        sv = (cyc >= t_vstart) && (cyc <= t_done);
        r0 = (cyc == t_ready) && !tx_m;
        r1 = (cyc == t_ready) &&  tx_m;
        if (cyc == t_ready && tx_to) exp_err = tx_addr;
        chk("s_valid", {31'h0, s_valid_o}, {31'h0, sv});
        if (sv) begin
            chk("s_addr",  s_addr_o,  tx_addr);
            chk("s_wdata", s_wdata_o, tx_wdata);
            chk("s_wstrb", {28'h0, s_wstrb_o}, {28'h0, tx_wstrb});
        end
        chk("m0_ready", {31'h0, m0_ready_o}, {31'h0, r0});
        chk("m0_rdata", m0_rdata_o, r0 ? tx_rdata : 32'h0);
        chk("m1_ready", {31'h0, m1_ready_o}, {31'h0, r1});
        chk("m1_rdata", m1_rdata_o, r1 ? tx_rdata : 32'h0);
        chk("timeout",  {31'h0, timeout_o}, {31'h0, (cyc == t_ready) && tx_to});
        chk("err_addr", err_addr_o, exp_err);
    endtask

    task automatic observe();
        if (m0_ready_o) begin obs_m.push_back(0); obs_c.push_back(cyc); obs_d.push_back(m0_rdata_o); obs_t.push_back(timeout_o); end
        if (m1_ready_o) begin obs_m.push_back(1); obs_c.push_back(cyc); obs_d.push_back(m1_rdata_o); obs_t.push_back(timeout_o); end
        if (s_valid_o) sv_cnt++;
        if (lit_w && s_valid_o) begin
            chk("wr_s_addr",  s_addr_o,  32'h0100_0004);
            chk("wr_s_wdata", s_wdata_o, 32'hA5A5_A5A5);
            chk("wr_s_wstrb", {28'h0, s_wstrb_o}, 32'h3);
        end
    endtask

    // Inputs for the current cycle, plus the arbitration decision taken at
    // the edge that ends it.
    task automatic drive();
        bit w;
        int lat, c;
        if (cyc == t_ready && !sticky) mreq[tx_m] = 0;
        for (int i = 0; i < 2; i++) begin
            if (rand_mode) begin
                if (!mreq[i] && $urandom_range(0, 3) == 0) mreq[i] = 1;
                maddr[i]  = $urandom;
                mwdata[i] = $urandom;
                mwstrb[i] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            end else if (scramble && i == int'(tx_m) && cyc >= t_vstart && cyc <= t_done) begin
                maddr[i]  = $urandom;
                mwdata[i] = $urandom;
                mwstrb[i] = 4'($urandom);
            end
        end

        srdata = $urandom;
        if (cyc == t_done && !tx_to) begin
            if (!rand_mode) srdata = dir_rdata;
            tx_rdata = srdata;
        end
        if (cyc >= t_vstart && cyc <= t_done) srdy = (cyc == t_done) && !tx_to;
        else                                   srdy = ($urandom_range(0, 2) == 0);

        if (cyc >= t_free && (mreq[0] || mreq[1])) begin
            w = (mreq[0] && mreq[1]) ? !last_winner : mreq[1];
            last_winner = w;
            tx_m = w; tx_addr = maddr[w]; tx_wdata = mwdata[w]; tx_wstrb = mwstrb[w];
            g_cyc = cyc;
            if (rand_mode) lat = ($urandom_range(0, 5) == 0) ? T + 1 + $urandom_range(0, 3) : $urandom_range(1, T);
            else           lat = dir_lat;
            tx_to = (lat > T);
            c = tx_to ? T : lat;
            t_vstart = cyc + 1;
            t_done   = cyc + c;
            t_ready  = cyc + c + 1;
            t_free   = cyc + c + 2;
            if (tx_to) tx_rdata = TO_DATA;
        end
        apply_ports();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        observe();
        drive();
    endtask

    task automatic run_until(input int n, input int bound);
        int k = 0;
        while (obs_m.size() < n && k < bound) begin step(); k++; end
        if (obs_m.size() < n) begin
            total++; bad++;
            $display("FAIL wait_done got=%0d want=%0d", obs_m.size(), n);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((mreq[0] || mreq[1] || cyc <= t_free) && k < 200) begin step(); k++; end
        if (k >= 200) begin
            total++; bad++;
            $display("FAIL drain got=busy want=idle");
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_s_valid",  {31'h0, s_valid_o},  32'h0);
        chk("rst_s_addr",   s_addr_o,            32'h0);
        chk("rst_m0_ready", {31'h0, m0_ready_o}, 32'h0);
        chk("rst_m0_rdata", m0_rdata_o,          32'h0);
        chk("rst_m1_ready", {31'h0, m1_ready_o}, 32'h0);
        chk("rst_timeout",  {31'h0, timeout_o},  32'h0);
        chk("rst_err_addr", err_addr_o,          32'h0);
        model_reset();
        apply_ports();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=hang want=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ord;
        int         n0;
        for (int i = 0; i < 2; i++) begin maddr[i] = 0; mwdata[i] = 0; mwstrb[i] = 0; end
        model_reset();
        obs_clear();
        apply_ports();
        do_reset();

        // single read, k=1
        obs_clear();
        maddr[0] = 32'h0100_0010; mwdata[0] = 32'h0; mwstrb[0] = 4'h0; mreq[0] = 1;
        dir_lat = 1; dir_rdata = 32'h1234_5678;
        run_until(1, 20);
        drain();
        if (obs_m.size() > 0) begin
            chk("single_lat",    obs_c[0] - g_cyc, 32'd2);
            chk("single_rdata",  obs_d[0], 32'h1234_5678);
            chk("single_master", {31'h0, obs_m[0]}, 32'h0);
        end
        chk("single_sv_cycles", sv_cnt, 32'd1);

        // contention: both masters request continuously
        do_reset();
        obs_clear();
        sticky = 1; mreq[0] = 1; mreq[1] = 1; dir_lat = 1;
        run_until(8, 100);
        sticky = 0;
        drain();
        ord = 8'h0; n0 = 0;
        for (int i = 0; i < 8 && i < obs_m.size(); i++) begin
            ord[i] = obs_m[i];
            if (!obs_m[i]) n0++;
        end
        chk("contention_order", {24'h0, ord}, 32'h0000_00AA);
        chk("contention_m0_cnt", n0, 32'd4);

        // write passthrough with master inputs scrambled during GRANT
        obs_clear();
        maddr[1] = 32'h0100_0004; mwdata[1] = 32'hA5A5_A5A5; mwstrb[1] = 4'b0011; mreq[1] = 1;
        scramble = 1; lit_w = 1; dir_lat = 3;
        run_until(1, 20);
        lit_w = 0; scramble = 0;
        drain();
        if (obs_m.size() > 0) chk("wr_master", {31'h0, obs_m[0]}, 32'h1);

        // timeout
        obs_clear();
        maddr[0] = 32'h2000_0000; mwstrb[0] = 4'h0; mreq[0] = 1; dir_lat = 100;
        run_until(1, 30);
        drain();
        if (obs_m.size() > 0) begin
            chk("to_lat",   obs_c[0] - g_cyc, 32'd5);
            chk("to_rdata", obs_d[0], 32'hDEAD_BEEF);
            chk("to_pulse", {31'h0, obs_t[0]}, 32'h1);
        end
        repeat (5) step();
        chk("to_err_hold", err_addr_o, 32'h2000_0000);

        // ready in the last watchdog cycle
        obs_clear();
        maddr[0] = 32'h3000_0000; mreq[0] = 1; dir_lat = T; dir_rdata = 32'h0000_0042;
        run_until(1, 30);
        drain();
        if (obs_m.size() > 0) begin
            chk("col_lat",   obs_c[0] - g_cyc, 32'd5);
            chk("col_rdata", obs_d[0], 32'h0000_0042);
            chk("col_no_to", {31'h0, obs_t[0]}, 32'h0);
        end
        chk("col_err_keep", err_addr_o, 32'h2000_0000);

        // reset in the middle of a transaction
        maddr[0] = 32'h4000_0000; mreq[0] = 1; dir_lat = 100;
        repeat (3) step();
        do_reset();
        obs_clear();
        mreq[0] = 1; mreq[1] = 1; dir_lat = 1;
        run_until(1, 20);
        if (obs_m.size() > 0) chk("rst_first_m0", {31'h0, obs_m[0]}, 32'h0);
        drain();

        // randomized traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
